// File: rtl/adc_seq_pkg.sv
// Shared types for the ADC capture sequencer: FSM states, latched run config, FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_seq_pkg;

    localparam int SEQ_DATA_W = 16;
    localparam int SEQ_LEN_W  = 16;

    localparam logic [SEQ_LEN_W-1:0] LEN_ONE = SEQ_LEN_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Run configuration captured on an accepted start; frame_len is stored
    // already corrected so a programmed 0 behaves as 1.
    typedef struct packed {
        logic [SEQ_LEN_W-1:0] frame_len;
        logic [SEQ_LEN_W-1:0] num_frames;
        logic [SEQ_LEN_W-1:0] decim;
        logic                 trig_en;
    } cfg_t;

    typedef struct packed {
        logic                  last;
        logic [SEQ_DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic logic [SEQ_LEN_W-1:0] len_eff(input logic [SEQ_LEN_W-1:0] len);
        return (len == '0) ? LEN_ONE : len;
    endfunction

endpackage

// File: rtl/adc_seq_fifo.sv
// Small synchronous FIFO holding {tlast, sample} entries between capture and the stream port.
// Latency: a push is visible on o_rd_dat / !o_empty the cycle after it is written.
// Backpressure: o_full blocks a push unless a pop happens in the same cycle; a blocked push is simply not stored.
//
// Ports: core_clk/arst_n clock and async active-low flush; i_wr_vld/i_wr_dat write side;
//        i_rd_rdy pop request, o_rd_dat head entry; o_full/o_empty occupancy flags.
module adc_seq_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_rdy,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign w_pop    = i_rd_rdy && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts a write.
    assign w_push   = i_wr_vld && (!o_full || w_pop);
    assign o_rd_dat = r_mem[r_rd_ptr];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Frame-based ADC capture sequencer: optional trigger, decimation, framing with TLAST, AXI4-Stream output.
// Latency: an accepted ADC sample appears on m_axis_tvalid one cycle later when the buffer is empty.
// Backpressure: m_axis_tready stalls the buffer; the ADC cannot be stalled, so samples hitting a full buffer are dropped and flagged.
//
// Ports: ACLK/ARESETN clock and async active-low reset; ctrl_start/ctrl_stop run control pulses;
//        cfg_* run configuration (latched at start); trig_in external trigger; adc_valid/adc_data sample input;
//        m_axis_* stream master; sts_* busy/done/overflow flags and completed-frame count.
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int DATA_WIDTH = SEQ_DATA_W,
    parameter int AXIS_WIDTH = 32,
    parameter int LEN_WIDTH  = SEQ_LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  ctrl_start,
    input  logic                  ctrl_stop,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [LEN_WIDTH-1:0]  cfg_num_frames,
    input  logic [LEN_WIDTH-1:0]  cfg_decim,
    input  logic                  cfg_trig_en,
    input  logic                  trig_in,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_overflow,
    output logic [LEN_WIDTH-1:0]  sts_frame_cnt
);

    state_t               r_state;
    state_t               w_state_nxt;
    cfg_t                 r_cfg;
    logic                 r_trig_d;
    logic [LEN_WIDTH-1:0] r_decim_cnt;
    logic [LEN_WIDTH-1:0] r_samp_cnt;
    logic [LEN_WIDTH-1:0] r_frame_cnt;
    logic                 r_stop_pend;
    logic                 r_done;
    logic                 r_ovf;

    logic                 w_idle_like;
    logic                 w_in_capture;
    logic                 w_start;
    logic                 w_trig_edge;
    logic                 w_stop_empty;
    logic                 w_trunc;
    logic                 w_take;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_last;
    logic                 w_frame_end;
    logic                 w_run_end;
    logic                 w_full;
    logic                 w_empty;
    fifo_entry_t          w_wr_ent;
    fifo_entry_t          w_rd_ent;

    assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_in_capture = (r_state == ST_CAPTURE);
    assign w_start      = ctrl_start && w_idle_like;
    assign w_trig_edge  = trig_in && !r_trig_d;

    // Stop at a frame boundary ends the run without another sample; mid-frame
    // it truncates the frame at the next stored sample (this cycle's included).
    assign w_stop_empty = w_in_capture && ctrl_stop && (r_samp_cnt == '0);
    assign w_trunc      = r_stop_pend || (w_in_capture && ctrl_stop);

    assign w_take       = w_in_capture && adc_valid && (r_decim_cnt == '0) && !w_stop_empty;
    assign w_pop        = m_axis_tvalid && m_axis_tready;
    assign w_push       = w_take && (!w_full || w_pop);
    assign w_drop       = w_take && w_full && !w_pop;
    assign w_last       = (r_samp_cnt == r_cfg.frame_len - LEN_ONE) || w_trunc;
    assign w_frame_end  = w_push && w_last;
    assign w_run_end    = w_frame_end &&
                          (w_trunc || ((r_cfg.num_frames != '0) &&
                                       (r_frame_cnt + LEN_ONE == r_cfg.num_frames)));

    assign w_wr_ent.last = w_last;
    assign w_wr_ent.data = adc_data;

    adc_seq_fifo #(
        .WIDTH (($bits(fifo_entry_t))),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (ACLK),
        .arst_n   (ARESETN),
        .i_wr_vld (w_take),
        .i_wr_dat (w_wr_ent),
        .i_rd_rdy (m_axis_tready),
        .o_rd_dat (w_rd_ent),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = AXIS_WIDTH'(w_rd_ent.data);
    assign m_axis_tlast  = w_rd_ent.last;
    assign sts_busy      = !w_idle_like;
    assign sts_done      = r_done;
    assign sts_overflow  = r_ovf;
    assign sts_frame_cnt = r_frame_cnt;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (ctrl_start) begin
                    w_state_nxt = cfg_trig_en ? ST_ARM : ST_CAPTURE;
                end
            end
            ST_ARM: begin
                if (ctrl_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_trig_edge) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_stop_empty || w_run_end) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_frame_end && r_cfg.trig_en) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cfg       <= '0;
            r_trig_d    <= 1'b0;
            r_decim_cnt <= '0;
            r_samp_cnt  <= '0;
            r_frame_cnt <= '0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            // Tracks trig_in every cycle so a level held across ARM is not an edge.
            r_trig_d <= trig_in;
            if (w_start) begin
                r_cfg.frame_len  <= len_eff(cfg_frame_len);
                r_cfg.num_frames <= cfg_num_frames;
                r_cfg.decim      <= cfg_decim;
                r_cfg.trig_en    <= cfg_trig_en;
                r_decim_cnt      <= '0;
                r_samp_cnt       <= '0;
                r_frame_cnt      <= '0;
                r_stop_pend      <= 1'b0;
                r_done           <= 1'b0;
                r_ovf            <= 1'b0;
            end else begin
                // Frame entry restarts the decimation phase so the first sample is kept.
                if ((r_state == ST_ARM) && w_trig_edge) begin
                    r_decim_cnt <= '0;
                end
                if (w_in_capture && adc_valid && !w_stop_empty) begin
                    r_decim_cnt <= (r_decim_cnt == '0) ? r_cfg.decim : r_decim_cnt - LEN_ONE;
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
                if (w_in_capture && ctrl_stop && !w_stop_empty) begin
                    r_stop_pend <= 1'b1;
                end
                // Dropped samples leave the frame position untouched.
                if (w_push) begin
                    if (w_last) begin
                        r_samp_cnt  <= '0;
                        r_frame_cnt <= r_frame_cnt + LEN_ONE;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_samp_cnt  <= r_samp_cnt + LEN_ONE;
                    end
                end
                if ((r_state == ST_DRAIN) && w_empty) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
module tb_adc_capture_sequencer;

    localparam int DW = 16;
    localparam int XW = 32;
    localparam int LW = 16;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          ctrl_start = 1'b0;
    logic          ctrl_stop = 1'b0;
    logic [LW-1:0] cfg_frame_len = '0;
    logic [LW-1:0] cfg_num_frames = '0;
    logic [LW-1:0] cfg_decim = '0;
    logic          cfg_trig_en = 1'b0;
    logic          trig_in = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [XW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          sts_busy;
    logic          sts_done;
    logic          sts_overflow;
    logic [LW-1:0] sts_frame_cnt;

    always #5 ACLK = ~ACLK;

    adc_capture_sequencer #(
        .DATA_WIDTH (DW),
        .AXIS_WIDTH (XW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (4)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .ctrl_start     (ctrl_start),
        .ctrl_stop      (ctrl_stop),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_num_frames (cfg_num_frames),
        .cfg_decim      (cfg_decim),
        .cfg_trig_en    (cfg_trig_en),
        .trig_in        (trig_in),
        .adc_valid      (adc_valid),
        .adc_data       (adc_data),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .sts_busy       (sts_busy),
        .sts_done       (sts_done),
        .sts_overflow   (sts_overflow),
        .sts_frame_cnt  (sts_frame_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Beats are {tlast, tdata}; expected ones carry explicit zero-extension.
    logic [XW:0] got_q[$];
    logic [XW:0] exp_q[$];
    logic [DW-1:0] sd_q[$];
    bit            sv_q[$];

    int          stab_err = 0;
    logic        prev_hold = 1'b0;
    logic [XW:0] prev_beat = '0;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (!m_axis_tvalid || ({m_axis_tlast, m_axis_tdata} !== prev_beat)))
                stab_err++;
            if (m_axis_tvalid && m_axis_tready)
                got_q.push_back({m_axis_tlast, m_axis_tdata});
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_beat = {m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_run(input int len, input int frames, input int decim, input bit trig);
        cfg_frame_len  = LW'(len);
        cfg_num_frames = LW'(frames);
        cfg_decim      = LW'(decim);
        cfg_trig_en    = trig;
        ctrl_start     = 1'b1;
        step();
        ctrl_start     = 1'b0;
        // Later cfg changes must not affect the running capture.
        cfg_frame_len  = LW'($urandom);
        cfg_num_frames = LW'($urandom);
        cfg_decim      = LW'($urandom);
        cfg_trig_en    = 1'($urandom);
    endtask

    task automatic drive_stim();
        foreach (sv_q[i]) begin
            adc_valid = sv_q[i];
            adc_data  = sd_q[i];
            step();
        end
        adc_valid = 1'b0;
    endtask

    // Reference: of the valid samples seen since capture began, keep every
    // (decim+1)-th one; every len-th kept sample closes a frame; the run stops
    // after frames*len kept samples (no limit when frames==0).
    task automatic model_expected(input int len, input int frames, input int decim);
        int le;
        int k;
        int nk;
        int need;
        le   = (len == 0) ? 1 : len;
        need = (frames == 0) ? 32'h7fff_ffff : le * frames;
        k    = 0;
        nk   = 0;
        exp_q.delete();
        foreach (sv_q[i]) begin
            if (sv_q[i]) begin
                if ((k % (decim + 1)) == 0 && nk < need) begin
                    nk++;
                    exp_q.push_back({((nk % le) == 0), 16'h0000, sd_q[i]});
                end
                k++;
            end
        end
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 200 && sts_done !== 1'b1; c++) step();
        n_cmp++;
        if (sts_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_done_timeout: sts_done=%b want 1", name, sts_done);
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        n_cmp++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        n_cmp++; if (sts_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", sts_busy); end
        n_cmp++; if (sts_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", sts_done); end
        n_cmp++; if (sts_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", sts_overflow); end
        n_cmp++; if (sts_frame_cnt !== '0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", sts_frame_cnt); end
    endtask

    task automatic test_basic();
        m_axis_tready = 1'b1;
        got_q.delete();
        sv_q.delete(); sd_q.delete();
        for (int i = 1; i <= 12; i++) begin sv_q.push_back(1'b1); sd_q.push_back(DW'(i)); end
        model_expected(4, 2, 0);
        start_run(4, 2, 0, 1'b0);
        n_cmp++; if (sts_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", sts_busy); end
        foreach (sv_q[i]) begin
            adc_valid = sv_q[i];
            adc_data  = sd_q[i];
            step();
            if (i == 0) begin
                n_cmp++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1) begin
                    n_err++;
                    $display("FAIL basic_latency: tvalid=%b tdata=%h want 1/00000001", m_axis_tvalid, m_axis_tdata);
                end
            end
        end
        adc_valid = 1'b0;
        wait_done("basic");
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (sts_frame_cnt !== LW'(2)) begin n_err++; $display("FAIL basic_frame_cnt: got %0d want 2", sts_frame_cnt); end
        n_cmp++; if (sts_overflow !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b want 0", sts_overflow); end
        n_cmp++; if (sts_busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: busy=%b want 0", sts_busy); end
    endtask

    task automatic test_decim();
        got_q.delete();
        sv_q.delete(); sd_q.delete();
        for (int i = 0; i <= 11; i++) begin sv_q.push_back(1'b1); sd_q.push_back(DW'(i)); end
        model_expected(3, 1, 2);
        start_run(3, 1, 2, 1'b0);
        n_cmp++; if (sts_done !== 1'b0) begin n_err++; $display("FAIL decim_done_cleared: got %b want 0", sts_done); end
        drive_stim();
        wait_done("decim");
        n_cmp++; if (got_q.size() != 3) begin n_err++; $display("FAIL decim_count: got %0d beats want 3", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL decim_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (sts_frame_cnt !== LW'(1)) begin n_err++; $display("FAIL decim_frame_cnt: got %0d want 1", sts_frame_cnt); end
    endtask

    task automatic test_trigger();
        got_q.delete();
        exp_q.delete();
        exp_q.push_back({1'b0, 32'd11});
        exp_q.push_back({1'b1, 32'd12});
        // Two frames requested: the second must never start while trig stays high.
        start_run(2, 2, 0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(i);
            trig_in   = (i >= 10);
            step();
        end
        adc_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL trig_count: got %0d beats want 2", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL trig_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (sts_busy !== 1'b1) begin n_err++; $display("FAIL trig_armed_busy: got %b want 1", sts_busy); end
        n_cmp++; if (sts_frame_cnt !== LW'(1)) begin n_err++; $display("FAIL trig_frame_cnt: got %0d want 1", sts_frame_cnt); end
        ctrl_stop = 1'b1;
        step();
        ctrl_stop = 1'b0;
        trig_in   = 1'b0;
        n_cmp++; if (sts_busy !== 1'b0) begin n_err++; $display("FAIL trig_stop_busy: got %b want 0", sts_busy); end
        n_cmp++; if (sts_done !== 1'b0) begin n_err++; $display("FAIL trig_stop_done: got %b want 0", sts_done); end
    endtask

    task automatic test_overflow();
        got_q.delete();
        stab_err = 0;
        exp_q.delete();
        for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, 32'(i)});
        exp_q.push_back({1'b1, 32'd99});
        m_axis_tready = 1'b0;
        start_run(100, 1, 0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(i);
            step();
        end
        adc_valid = 1'b0;
        n_cmp++; if (sts_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", sts_overflow); end
        n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1) begin n_err++; $display("FAIL ovf_head: tvalid=%b tdata=%h want 1/00000001", m_axis_tvalid, m_axis_tdata); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        ctrl_stop = 1'b1;
        step();
        ctrl_stop = 1'b0;
        adc_valid = 1'b1;
        adc_data  = DW'(99);
        step();
        adc_valid = 1'b0;
        wait_done("ovf");
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL ovf_stable: %0d unstable stalled beats, want 0", stab_err); end
        n_cmp++; if (sts_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", sts_overflow); end
        n_cmp++; if (sts_frame_cnt !== LW'(1)) begin n_err++; $display("FAIL ovf_frame_cnt: got %0d want 1", sts_frame_cnt); end
    endtask

    task automatic test_continuous();
        got_q.delete();
        exp_q.delete();
        for (int i = 1; i <= 13; i++) exp_q.push_back({(i == 5 || i == 10 || i == 13), 32'(i)});
        start_run(5, 0, 0, 1'b0);
        n_cmp++; if (sts_overflow !== 1'b0) begin n_err++; $display("FAIL cont_ovf_cleared: got %b want 0", sts_overflow); end
        for (int i = 1; i <= 12; i++) begin
            adc_valid  = 1'b1;
            adc_data   = DW'(i);
            ctrl_start = (i == 7);   // must be ignored mid-run
            step();
        end
        ctrl_start = 1'b0;
        adc_valid  = 1'b0;
        ctrl_stop  = 1'b1;
        step();
        ctrl_stop  = 1'b0;
        for (int i = 13; i <= 15; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(i);
            step();
        end
        adc_valid = 1'b0;
        wait_done("cont");
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL cont_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL cont_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (sts_frame_cnt !== LW'(3)) begin n_err++; $display("FAIL cont_frame_cnt: got %0d want 3", sts_frame_cnt); end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 1'b0;
        start_run(1, 0, 0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(40 + i);
            step();
        end
        adc_valid = 1'b0;
        n_cmp++; if (sts_frame_cnt !== LW'(3) || m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: frame_cnt=%0d tvalid=%b want 3/1", sts_frame_cnt, m_axis_tvalid); end
        ARESETN = 1'b0;
        #1;
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (sts_busy !== 1'b0 || sts_done !== 1'b0 || sts_overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_status: busy=%b done=%b ovf=%b want 0/0/0", sts_busy, sts_done, sts_overflow); end
        n_cmp++; if (sts_frame_cnt !== '0) begin n_err++; $display("FAIL rstmid_frame_cnt: got %0d want 0", sts_frame_cnt); end
        step();
        step();
        ARESETN = 1'b1;
        m_axis_tready = 1'b1;
        step();
        got_q.delete();
        sv_q.delete(); sd_q.delete();
        for (int i = 0; i < 10; i++) begin sv_q.push_back(1'b1); sd_q.push_back(DW'($urandom)); end
        model_expected(3, 2, 0);
        start_run(3, 2, 0, 1'b0);
        drive_stim();
        wait_done("rstmid");
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_count: got %0d beats want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int len;
            int frames;
            int decim;
            int le;
            int vcnt;
            int target;
            len    = $urandom_range(0, 6);
            frames = $urandom_range(1, 3);
            decim  = $urandom_range(0, 3);
            le     = (len == 0) ? 1 : len;
            target = le * frames * (decim + 1);
            got_q.delete();
            sv_q.delete(); sd_q.delete();
            vcnt = 0;
            while (vcnt < target) begin
                bit v;
                v = ($urandom_range(0, 3) != 0);
                sv_q.push_back(v);
                sd_q.push_back(DW'($urandom));
                if (v) vcnt++;
            end
            for (int i = 0; i < 4; i++) begin sv_q.push_back(1'b1); sd_q.push_back(DW'($urandom)); end
            model_expected(len, frames, decim);
            start_run(len, frames, decim, 1'b0);
            drive_stim();
            wait_done($sformatf("rand%0d", it));
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d beats want %0d", it, got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
            end
            n_cmp++; if (sts_frame_cnt !== LW'(frames)) begin n_err++; $display("FAIL rand%0d_frame_cnt: got %0d want %0d", it, sts_frame_cnt, frames); end
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        step();
        step();
        test_reset();
        ARESETN = 1'b1;
        step();
        test_reset();
        test_basic();
        test_decim();
        test_trigger();
        test_overflow();
        test_continuous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
